updi_phy_tx: RTL and testbench
==============================

UPDI_PHY_TX -- requirements
Module: updi_phy_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning i_clk cycles per UART bit (legal range 2..255).
REQ-002 SHALL have parameter GUARD_BITS, default 2, meaning idle-high bit times inserted after each frame (legal range 0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port i_clk, input, 1, the single clock.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_data, input, 12, frame from the character generator: [11] start, [10:3] data byte, [2] parity, [1:0] stop.
REQ-007 SHALL have port i_valid, input, 1, frame on i_data is valid.
REQ-008 SHALL have port o_ready, output, 1, block can accept a frame this cycle.
REQ-009 SHALL have port o_tx, output, 1, serial UPDI line drive, idle high.
REQ-010 SHALL have port o_busy, output, 1, high while in SHIFT or GUARD.
REQ-011 SHALL have port o_done, output, 1, one-cycle pulse after the last stop bit of a frame.
REQ-012 SHALL have port o_err, output, 1, one-cycle pulse on frame rejection (see REQ-030).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, GUARD.
REQ-014 SHALL accept a frame on a rising edge where i_valid && o_ready, latching i_data into a 12-bit shadow register.
REQ-015 SHALL drive o_ready = 1 only in IDLE, combinationally from state and independent of i_valid.
REQ-016 SHALL move IDLE->SHIFT on accept; o_tx carries the start bit from the cycle after the accept edge.
REQ-017 SHALL transmit bits in order [11], [3], [4], [5], [6], [7], [8], [9], [10], [2], [1], [0], i.e. data LSB first.
REQ-018 SHALL hold each bit on o_tx for exactly CLK_DIV cycles, using a baud counter 0..CLK_DIV-1 and a bit counter 0..11.
REQ-019 SHALL pulse o_done for one cycle in the first cycle after the 12th bit time, coincident with leaving SHIFT.
REQ-020 SHALL move SHIFT->GUARD after the 12th bit, holding o_tx = 1 for GUARD_BITS*CLK_DIV cycles, then GUARD->IDLE.
REQ-021 SHALL move SHIFT->IDLE directly when GUARD_BITS = 0.
REQ-022 SHALL assert o_ready again exactly (12+GUARD_BITS)*CLK_DIV cycles after the accept edge, allowing back-to-back frames with no additional gap.
REQ-023 SHALL ignore i_valid and i_data while not in IDLE; the shadow register is never overwritten mid-frame.
REQ-024 SHALL drive o_tx = 1 in IDLE and GUARD.
REQ-025 SHALL register o_tx with no combinational path from i_data.

Reset
REQ-026 SHALL, on i_rst = 1 at any time including mid-frame, immediately force state IDLE, all counters 0, shadow register 12'hFFF, o_tx = 1, o_busy = 0, o_done = 0, o_err = 0.
REQ-027 SHALL keep o_ready = 0 while i_rst is high and for the first cycle after release, with o_ready = 1 from the second cycle.
REQ-028 SHALL NOT resume an interrupted frame after reset; the upstream re-sends it.

Configuration
REQ-029 SHALL compile frame checking in only when macro UPDI_TX_FRAME_CHK_EN is defined.
REQ-030 SHALL, with UPDI_TX_FRAME_CHK_EN defined, check on accept that [11] = 0, [1:0] = 2'b11 and [2] = ^[10:3]; on failure the frame is dropped, o_err pulses one cycle, o_tx stays 1, and the state remains IDLE.
REQ-031 SHALL, without UPDI_TX_FRAME_CHK_EN, tie o_err to 0 and transmit every accepted frame verbatim.

Verification (CLK_DIV=4, GUARD_BITS=2)
REQ-032 SHALL cover: SYNCH frame 12'b0_01010101_011 -> o_tx = 0,1,0,1,0,1,0,1,0,0,1,1 with each bit held 4 cycles, o_done pulse at cycle 49 after accept, o_ready back at cycle 56.
REQ-033 SHALL cover: frame 12'b0_10100000_011 (REPEAT) -> o_tx = 0,0,0,0,0,0,1,0,1,0,1,1.
REQ-034 SHALL cover: i_valid held high across 3 random frames -> accepts exactly 56 cycles apart, each byte recovered LSB-first equals the sent byte, and the 8 guard cycles stay high.
REQ-035 SHALL cover: i_rst pulsed during bit 5 -> o_tx = 1 in the same cycle, o_ready = 1 on the second cycle after release, and a new frame is sent correctly.
REQ-036 SHALL cover: with UPDI_TX_FRAME_CHK_EN, 12'b0_01010101_111 -> o_err 1-cycle pulse, o_tx constant 1, o_ready stays 1; without the macro the same frame is sent verbatim.
REQ-037 SHALL cover: GUARD_BITS=0 -> back-to-back frames 48 cycles apart with no idle bit between the stop and start bits.

Source files
------------

// File: rtl/updi_phy_tx.sv
// UPDI UART transmit PHY: shifts 12-bit frames LSB-first, then holds the line idle for a guard time.
// Optional macro UPDI_TX_FRAME_CHK_EN rejects malformed frames on accept with an o_err pulse.
module updi_phy_tx #(
   parameter int CLK_DIV    = 16,
   parameter int GUARD_BITS = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [11:0] i_data,
   input  logic        i_valid,
   output logic        o_ready,
   output logic        o_tx,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   localparam logic [7:0] BAUD_LAST  = 8'(CLK_DIV - 1);
   localparam logic [7:0] BAUD_PRE   = 8'(CLK_DIV - 2);
   localparam logic [3:0] LAST_BIT   = 4'd11;
   localparam logic [3:0] GUARD_LAST = 4'(GUARD_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GUARD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  baud_q, baud_d;
   logic [3:0]  bit_q, bit_d;
   logic [11:0] shadow_q, shadow_d;
   logic        tx_q, tx_d;
   logic        done_q, done_d;
   logic        tail_q, tail_d;
   logic        rdy_en_q;
   logic        accept;
   logic        frame_ok;

   // Line order: start, data LSB..MSB, parity, stop[1], stop[0].
   function automatic logic [3:0] bit_index(input logic [3:0] pos);
      logic [3:0] idx;
      case (pos)
         4'd0:                                          idx = 4'd11;
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: idx = pos + 4'd2;
         4'd9:                                          idx = 4'd2;
         4'd10:                                         idx = 4'd1;
         default:                                       idx = 4'd0;
      endcase
      return idx;
   endfunction

   assign accept  = i_valid && o_ready;
   assign o_ready = rdy_en_q && (state_q == IDLE);
   assign o_busy  = (state_q == SHIFT) || (state_q == GUARD);
   assign o_tx    = tx_q;
   assign o_done  = done_q;

`ifdef UPDI_TX_FRAME_CHK_EN
   logic err_q, err_d;

   assign frame_ok = (i_data[11] == 1'b0) && (i_data[1:0] == 2'b11) && (i_data[2] == ^i_data[10:3]);

   always_comb begin
      err_d = accept && !frame_ok;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign o_err = err_q;
`else
   assign frame_ok = 1'b1;
   assign o_err    = 1'b0;
`endif

   // The FSM leaves each state one cycle ahead of the registered line so o_ready
   // lines up with the end of the frame and back-to-back frames have no gap.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shadow_d = shadow_q;
      tx_d     = tx_q;
      done_d   = 1'b0;
      tail_d   = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            done_d = tail_q;
            baud_d = 8'd0;
            bit_d  = 4'd0;
            if (accept && frame_ok) begin
               shadow_d = i_data;
               tx_d     = i_data[11];
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = 8'd0;
               bit_d  = bit_q + 4'd1;
               tx_d   = shadow_q[bit_index(bit_q + 4'd1)];
            end else begin
               baud_d = baud_q + 8'd1;
            end
            if (bit_q == LAST_BIT) begin
               if (GUARD_BITS == 0 && baud_q == BAUD_PRE) begin
                  state_d = IDLE;
                  tail_d  = 1'b1;
                  baud_d  = 8'd0;
                  bit_d   = 4'd0;
               end else if (GUARD_BITS != 0 && baud_q == BAUD_LAST) begin
                  state_d = GUARD;
                  tx_d    = 1'b1;
                  done_d  = 1'b1;
                  baud_d  = 8'd0;
                  bit_d   = 4'd0;
               end
            end
         end
         GUARD: begin
            tx_d = 1'b1;
            if (baud_q == BAUD_LAST) begin
               baud_d = 8'd0;
               bit_d  = bit_q + 4'd1;
            end else begin
               baud_d = baud_q + 8'd1;
            end
            if (bit_q == GUARD_LAST && baud_q == BAUD_PRE) begin
               state_d = IDLE;
               baud_d  = 8'd0;
               bit_d   = 4'd0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         baud_q   <= 8'd0;
         bit_q    <= 4'd0;
         shadow_q <= 12'hFFF;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
         tail_q   <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shadow_q <= shadow_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
         tail_q   <= tail_d;
         rdy_en_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_updi_phy_tx.sv
// Self-checking bench for updi_phy_tx: table vectors, random back-to-back frames,
// mid-frame reset, frame rejection and a zero-guard-time instance.
module tb_updi_phy_tx;

   localparam int CLK_DIV    = 4;
   localparam int GUARD_BITS = 2;
   localparam int BIT_CYC    = 12 * CLK_DIV;
   localparam int FRAME_CYC  = (12 + GUARD_BITS) * CLK_DIV;

   logic        i_clk;
   logic        i_rst;
   logic [11:0] i_data;
   logic        i_valid;
   logic        o_ready, o_tx, o_busy, o_done, o_err;

   logic [11:0] i_data0;
   logic        i_valid0;
   logic        o_ready0, o_tx0, o_busy0, o_done0, o_err0;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [11:0] frame;
      logic [11:0] seq;
   } vec_t;

   vec_t tbl[5];

   logic line_s[0:255];
   logic done_s[0:255];
   int   acc[3];

   updi_phy_tx #(.CLK_DIV(CLK_DIV), .GUARD_BITS(GUARD_BITS)) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_data (i_data),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .o_tx   (o_tx),
      .o_busy (o_busy),
      .o_done (o_done),
      .o_err  (o_err)
   );

   updi_phy_tx #(.CLK_DIV(CLK_DIV), .GUARD_BITS(0)) dut0 (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_data (i_data0),
      .i_valid(i_valid0),
      .o_ready(o_ready0),
      .o_tx   (o_tx0),
      .o_busy (o_busy0),
      .o_done (o_done0),
      .o_err  (o_err0)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: a legal frame built from a byte, and the line bits in send order (MSB of seq first).
   function automatic logic [11:0] make_frame(input logic [7:0] b);
      return {1'b0, b, ^b, 2'b11};
   endfunction

   function automatic logic [11:0] line_model(input logic start, input logic [7:0] b,
                                              input logic p, input logic [1:0] stop);
      logic [11:0] s;
      s[11] = start;
      for (int k = 0; k < 8; k++) s[10-k] = b[k];
      s[2] = p;
      s[1] = stop[1];
      s[0] = stop[0];
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Waits (bounded) for o_ready, presents a frame for one accept edge, returns #1 after it.
   task automatic applyStimulus(input logic [11:0] frame);
      for (int t = 0; t < 200 && !o_ready; t++) begin
         @(posedge i_clk);
         #1;
      end
      if (!o_ready) checkOutput("ready_timeout", 32'(o_ready), 32'd1);
      i_data  = frame;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_data  = 12'($urandom);
   endtask

   // Checks one full frame period, cycles 1..FRAME_CYC after the accept edge,
   // while throwing junk at i_valid/i_data during the frame.
   task automatic checkFrame(input logic [11:0] seq, input string name);
      for (int c = 1; c <= FRAME_CYC; c++) begin
         checkOutput({name, "_tx"},    32'(o_tx),    (c <= BIT_CYC) ? 32'(seq[11 - (c-1)/CLK_DIV]) : 32'd1);
         checkOutput({name, "_done"},  32'(o_done),  32'(c == BIT_CYC + 1));
         checkOutput({name, "_ready"}, 32'(o_ready), 32'(c == FRAME_CYC));
         checkOutput({name, "_busy"},  32'(o_busy),  32'(c < FRAME_CYC));
         i_valid = (c >= 2 && c <= 40) ? 1'($urandom) : 1'b0;
         i_data  = 12'($urandom);
         @(posedge i_clk);
         #1;
      end
      i_valid = 1'b0;
   endtask

   initial begin
      logic [7:0]  b[3];
      logic [11:0] fr, sq, bad;
      logic [23:0] two;
      logic [7:0]  rec;
      logic        rdy;
      int          idx;

      i_rst    = 1'b1;
      i_valid  = 1'b0;
      i_data   = 12'h000;
      i_valid0 = 1'b0;
      i_data0  = 12'h000;

      tbl[0].frame = 12'b0_01010101_011; tbl[0].seq = 12'b010101010011;
      tbl[1].frame = 12'b0_10100000_011; tbl[1].seq = 12'b000000101011;
      for (int i = 2; i < 5; i++) begin
         b[0] = 8'($urandom);
         tbl[i].frame = make_frame(b[0]);
         tbl[i].seq   = line_model(1'b0, b[0], ^b[0], 2'b11);
      end

      $display("[TB] reset checks");
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("rst_tx", 32'(o_tx), 32'd1);
      checkOutput("rst_ready", 32'(o_ready), 32'd0);
      i_rst = 1'b0;
      #1;
      checkOutput("rel_ready", 32'(o_ready), 32'd0);
      checkOutput("rel_busy", 32'(o_busy), 32'd0);
      checkOutput("rel_done", 32'(o_done), 32'd0);
      checkOutput("rel_err", 32'(o_err), 32'd0);
      @(posedge i_clk);
      #1;
      checkOutput("rel2_ready", 32'(o_ready), 32'd1);
      checkOutput("rel2_ready0", 32'(o_ready0), 32'd1);

      $display("[TB] table vectors");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(tbl[i].frame);
         checkFrame(tbl[i].seq, $sformatf("vec%0d", i));
      end

      $display("[TB] back-to-back frames with i_valid held");
      for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
      i_data  = make_frame(b[0]);
      i_valid = 1'b1;
      idx     = 0;
      for (int cyc = 0; cyc < 180; cyc++) begin
         @(negedge i_clk);
         line_s[cyc] = o_tx;
         rdy = o_ready;
         @(posedge i_clk);
         #1;
         if (rdy && idx < 3) begin
            acc[idx] = cyc;
            idx++;
            if (idx < 3) i_data = make_frame(b[idx]);
            else         i_valid = 1'b0;
         end
      end
      i_valid = 1'b0;
      checkOutput("b2b_accepts", 32'(idx), 32'd3);
      if (idx == 3) begin
         checkOutput("b2b_gap1", 32'(acc[1] - acc[0]), 32'(FRAME_CYC));
         checkOutput("b2b_gap2", 32'(acc[2] - acc[1]), 32'(FRAME_CYC));
         for (int f = 0; f < 3; f++) begin
            checkOutput("b2b_start", 32'(line_s[acc[f] + 2]), 32'd0);
            for (int k = 0; k < 8; k++) rec[k] = line_s[acc[f] + 1 + CLK_DIV*(k+1) + 2];
            checkOutput("b2b_byte", 32'(rec), 32'(b[f]));
            for (int g = BIT_CYC + 1; g <= FRAME_CYC; g++)
               checkOutput("b2b_guard", 32'(line_s[acc[f] + g]), 32'd1);
         end
      end

      $display("[TB] reset during bit 5");
      b[0] = 8'($urandom);
      sq   = line_model(1'b0, b[0], ^b[0], 2'b11);
      applyStimulus(make_frame(b[0]));
      repeat (21) begin
         @(posedge i_clk);
         #1;
      end
      checkOutput("mid_bit5", 32'(o_tx), 32'(sq[6]));
      #2;
      i_rst = 1'b1;
      #1;
      checkOutput("mid_rst_tx", 32'(o_tx), 32'd1);
      checkOutput("mid_rst_busy", 32'(o_busy), 32'd0);
      checkOutput("mid_rst_ready", 32'(o_ready), 32'd0);
      checkOutput("mid_rst_done", 32'(o_done), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      checkOutput("mid_rel_ready", 32'(o_ready), 32'd0);
      @(posedge i_clk);
      #1;
      checkOutput("mid_rel2_ready", 32'(o_ready), 32'd1);
      checkOutput("mid_rel2_tx", 32'(o_tx), 32'd1);
      b[1] = 8'($urandom);
      applyStimulus(make_frame(b[1]));
      checkFrame(line_model(1'b0, b[1], ^b[1], 2'b11), "after_rst");

      $display("[TB] bad parity frame");
      bad = 12'b0_01010101_111;
`ifdef UPDI_TX_FRAME_CHK_EN
      applyStimulus(bad);
      for (int c = 1; c <= 8; c++) begin
         checkOutput("chk_err", 32'(o_err), 32'(c == 1));
         checkOutput("chk_tx", 32'(o_tx), 32'd1);
         checkOutput("chk_ready", 32'(o_ready), 32'd1);
         @(posedge i_clk);
         #1;
      end
`else
      applyStimulus(bad);
      checkFrame(line_model(1'b0, 8'b01010101, 1'b1, 2'b11), "verbatim");
      checkOutput("nochk_err", 32'(o_err), 32'd0);
`endif

      $display("[TB] zero guard time, back-to-back");
      b[0] = 8'($urandom);
      b[1] = 8'($urandom);
      two  = {line_model(1'b0, b[0], ^b[0], 2'b11), line_model(1'b0, b[1], ^b[1], 2'b11)};
      i_data0  = make_frame(b[0]);
      i_valid0 = 1'b1;
      idx      = 0;
      for (int cyc = 0; cyc < 130; cyc++) begin
         @(negedge i_clk);
         line_s[cyc] = o_tx0;
         done_s[cyc] = o_done0;
         rdy = o_ready0;
         @(posedge i_clk);
         #1;
         if (rdy && idx < 2) begin
            acc[idx] = cyc;
            idx++;
            if (idx < 2) i_data0 = make_frame(b[1]);
            else         i_valid0 = 1'b0;
         end
      end
      i_valid0 = 1'b0;
      checkOutput("g0_accepts", 32'(idx), 32'd2);
      if (idx == 2) begin
         checkOutput("g0_gap", 32'(acc[1] - acc[0]), 32'(BIT_CYC));
         for (int c = 1; c <= 2*BIT_CYC; c++)
            checkOutput("g0_tx", 32'(line_s[acc[0] + c]), 32'(two[23 - (c-1)/CLK_DIV]));
         checkOutput("g0_done_pre", 32'(done_s[acc[0] + BIT_CYC]), 32'd0);
         checkOutput("g0_done", 32'(done_s[acc[0] + BIT_CYC + 1]), 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
